lsu: RTL and testbench

Load/store unit sitting directly upstream of the byte-lane data memory. It accepts one RV32 load or store request at a time from the execute stage over a valid/ready handshake. It drives the memory's per-byte active-low write enables, write lanes and byte address, then captures the synchronous read lanes. It returns a sign- or zero-extended 32-bit result, or a fault, over a second valid/ready handshake.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/lsu_load_format.sv | 22 ++
 rtl/lsu.sv | 134 +++++++++++++
 tb/tb_lsu.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Constants and types shared between the load/store unit, the data memory and writeback.
package mem_pkg;
    localparam int ADDR_WIDTH       = 32;
    localparam int DATA_WIDTH_BYTES = 4;
    localparam int MEM_SIZE_BYTES   = 4096;

    typedef enum logic [2:0] {
        F3_BYTE   = 3'b000,
        F3_HALF   = 3'b001,
        F3_WORD   = 3'b010,
        F3_BYTE_U = 3'b100,
        F3_HALF_U = 3'b101
    } funct3_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } lsu_state_t;

    function automatic logic [2:0] access_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] n);
        case (n)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction
endpackage

// File: rtl/lsu_load_format.sv
// Assembles the low n read lanes into a 32-bit word, sign- or zero-extended by funct3.
module lsu_load_format
    import mem_pkg::*;
(
    input  logic [3:0][7:0] lanes,
    input  logic [2:0]      funct3,
    input  logic [2:0]      n,
    output logic [31:0]     word
);
    logic sign_ext;

    assign sign_ext = (funct3 == F3_BYTE) || (funct3 == F3_HALF);

    always_comb begin
        word = {lanes[3], lanes[2], lanes[1], lanes[0]};
        case (n)
            3'd1:    word = {{24{sign_ext & lanes[0][7]}}, lanes[0]};
            3'd2:    word = {{16{sign_ext & lanes[1][7]}}, lanes[1], lanes[0]};
            default: word = {lanes[3], lanes[2], lanes[1], lanes[0]};
        endcase
    end
endmodule

// File: rtl/lsu.sv
// Load/store unit: one RV32 access at a time into the byte-lane data memory.
// State | meaning: IDLE accept | ISSUE drive memory | WAIT read lanes arrive | RESP hold response.
module lsu #(
    parameter int ADDR_WIDTH       = mem_pkg::ADDR_WIDTH,
    parameter int MEM_SIZE_BYTES   = mem_pkg::MEM_SIZE_BYTES,
    parameter int DATA_WIDTH_BYTES = mem_pkg::DATA_WIDTH_BYTES,
    parameter int ALLOW_MISALIGNED = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_we,
    input  logic [2:0]                       req_funct3,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [31:0]                      req_wdata,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [31:0]                      resp_rdata,
    output logic                             resp_fault,
    output logic [DATA_WIDTH_BYTES-1:0]      mem_wenableL,
    output logic [DATA_WIDTH_BYTES-1:0][7:0] mem_data_w,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic [DATA_WIDTH_BYTES-1:0][7:0] mem_data_r
);
    import mem_pkg::*;

    localparam int AW1 = ADDR_WIDTH + 1;

    if (DATA_WIDTH_BYTES != 4) begin : g_bad_lanes
        $error("lsu supports exactly 4 memory lanes");
    end

    lsu_state_t state_q, state_d;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [2:0]      req_n, n_q;
    logic [ADDR_WIDTH:0] req_end;
    logic            illegal, misaligned, out_of_range, req_fault, accept;
    logic [31:0]     load_word;

    assign req_n   = access_bytes(req_funct3[1:0]);
    assign n_q     = access_bytes(funct3_q[1:0]);
    // Extra bit keeps addr+n from wrapping near the top of the address space.
    assign req_end      = {1'b0, req_addr} + AW1'(req_n);
    assign out_of_range = req_end > AW1'(MEM_SIZE_BYTES);
    assign req_fault    = illegal | misaligned | out_of_range;

    always_comb begin
        illegal = 1'b1;
        case (req_funct3)
            F3_BYTE, F3_HALF, F3_WORD: illegal = 1'b0;
            F3_BYTE_U, F3_HALF_U:      illegal = req_we;
            default:                   illegal = 1'b1;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        if (ALLOW_MISALIGNED == 0) begin
            case (req_n)
                3'd2:    misaligned = req_addr[0];
                3'd4:    misaligned = |req_addr[1:0];
                default: misaligned = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = req_fault ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_RESP;
            ST_RESP:  if (resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    lsu_load_format u_load_format (
        .lanes  (mem_data_r),
        .funct3 (funct3_q),
        .n      (n_q),
        .word   (load_word)
    );

    // Write enables are registered so they are low for exactly the ISSUE cycle
    // and are forced high by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            resp_rdata   <= '0;
            resp_fault   <= 1'b0;
            mem_wenableL <= '1;
            mem_addr     <= '0;
            mem_data_w   <= '0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                if (req_fault) begin
                    resp_rdata <= '0;
                    resp_fault <= 1'b1;
                end else begin
                    mem_addr <= req_addr;
                    if (req_we) begin
                        mem_wenableL <= ~lane_mask(req_n);
                        mem_data_w   <= req_wdata;
                    end
                end
            end
            if (state_q == ST_ISSUE) mem_wenableL <= '1;
            if (state_q == ST_WAIT) begin
                resp_rdata <= we_q ? 32'h0 : load_word;
                resp_fault <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: instance 0 enforces alignment, instance 1 allows misaligned access.
module tb_lsu;
    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        string       name;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             resp_ready = 1'b1;
    logic             req_we = 1'b0;
    logic [2:0]       req_funct3 = 3'b000;
    logic [31:0]      req_addr = 32'h0;
    logic [31:0]      req_wdata = 32'h0;
    logic             req_valid  [2];
    logic             req_ready  [2];
    logic             resp_valid [2];
    logic [31:0]      resp_rdata [2];
    logic             resp_fault [2];
    logic [3:0]       wen        [2];
    logic [3:0][7:0]  mdw        [2];
    logic [31:0]      maddr      [2];

    exp_t exp_q [2][$];
    int   wen_low [2];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_u
        logic [3:0][7:0] mrd;
        logic [7:0]      mem [4096];
        int              acc_cyc = 0;
        int              first_cyc = 0;
        logic            prev_v = 1'b0;
        exp_t            e;

        lsu #(.ALLOW_MISALIGNED(g)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_we       (req_we),
            .req_funct3   (req_funct3),
            .req_addr     (req_addr),
            .req_wdata    (req_wdata),
            .resp_valid   (resp_valid[g]),
            .resp_ready   (resp_ready),
            .resp_rdata   (resp_rdata[g]),
            .resp_fault   (resp_fault[g]),
            .mem_wenableL (wen[g]),
            .mem_data_w   (mdw[g]),
            .mem_addr     (maddr[g]),
            .mem_data_r   (mrd)
        );

        // Memory: writes on any low enable, registered read one cycle later.
        always @(posedge clk) begin
            for (int i = 0; i < 4; i++) begin
                if (!wen[g][i]) mem[12'(maddr[g] + 32'(i))] <= mdw[g][i];
                mrd[i] <= mem[12'(maddr[g] + 32'(i))];
            end
        end

        always @(negedge clk) begin
            if (req_valid[g] && req_ready[g]) acc_cyc = cyc + 1;
            if (wen[g] != 4'hF) wen_low[g]++;
            if (resp_valid[g] && !prev_v) first_cyc = cyc;
            prev_v = resp_valid[g];
            if (resp_valid[g] && resp_ready) begin
                if (exp_q[g].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp inst%0d: got rdata 0x%08h, no response expected", g, resp_rdata[g]);
                end else begin
                    e = exp_q[g].pop_front();
                    check({e.name, "_rdata"}, resp_rdata[g], e.rdata);
                    check({e.name, "_fault"}, 32'(resp_fault[g]), 32'(e.fault));
                    check({e.name, "_latency"}, 32'(first_cyc - acc_cyc + 1), 32'(e.lat));
                end
            end
        end
    end

    task automatic push_exp(input int g, input logic [31:0] er, input logic ef, input string nm);
        exp_t e;
        e.rdata = er;
        e.fault = ef;
        e.lat   = ef ? 1 : 3;
        e.name  = nm;
        exp_q[g].push_back(e);
    endtask

    task automatic drain(input int g, input string nm);
        int n = 0;
        while (exp_q[g].size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q[g].size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d responses outstanding, expected 0", nm, exp_q[g].size());
            exp_q[g].delete();
        end
    endtask

    task automatic do_req(input int g, input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] er, input logic ef,
                          input string nm, input bit wait_resp = 1'b1);
        int n = 0;
        push_exp(g, er, ef, nm);
        @(posedge clk); #1;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_valid[g] = 1'b1;
        while (!req_ready[g] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready[g]) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: req_ready stuck at 0, expected 1", nm);
        end
        @(posedge clk); #1;
        req_valid[g] = 1'b0;
        if (wait_resp) drain(g, nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int wl;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        wen_low[0] = 0;
        wen_low[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  32'(req_ready[0]),  32'd1);
        check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_resp_rdata", resp_rdata[0],       32'd0);
        check("rst_resp_fault", 32'(resp_fault[0]), 32'd0);
        check("rst_wenableL",   32'(wen[0]),        32'hF);
        check("rst_mem_addr",   maddr[0],           32'd0);
        check("rst_mem_data_w", mdw[0],             32'd0);
        rst = 1'b0;

        do_req(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, "sw_10");
        do_req(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, "lw_10");
        do_req(0, 1, 3'b010, 32'h20, 32'h44332211, 32'h0, 0, "sw_20");
        do_req(0, 1, 3'b000, 32'h21, 32'h00000080, 32'h0, 0, "sb_21");
        do_req(0, 0, 3'b000, 32'h21, 32'h0, 32'hFFFFFF80, 0, "lb_21");
        do_req(0, 0, 3'b100, 32'h21, 32'h0, 32'h00000080, 0, "lbu_21");
        do_req(0, 0, 3'b010, 32'h20, 32'h0, 32'h44338011, 0, "lw_20_neighbours");
        do_req(0, 0, 3'b001, 32'h20, 32'h0, 32'hFFFF8011, 0, "lh_20");
        do_req(0, 0, 3'b101, 32'h22, 32'h0, 32'h00004433, 0, "lhu_22");

        do_req(0, 1, 3'b010, 32'hFFC, 32'h5A5A5A5A, 32'h0, 0, "sw_ffc");
        do_req(0, 1, 3'b001, 32'hFFE, 32'h0000BEEF, 32'h0, 0, "sh_ffe_top");
        do_req(0, 0, 3'b000, 32'hFFF, 32'h0, 32'hFFFFFFBE, 0, "lb_fff_top");

        wl = wen_low[0];
        do_req(0, 0, 3'b001, 32'h03, 32'h0, 32'h0, 1, "lh_03_misaligned");
        do_req(0, 1, 3'b010, 32'hFFE, 32'h12345678, 32'h0, 1, "sw_ffe_fault");
        do_req(0, 1, 3'b000, 32'h1000, 32'h000000AB, 32'h0, 1, "sb_1000_range");
        do_req(0, 0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1, "lw_wrap_range");
        do_req(0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, "f3_011_fault");
        do_req(0, 1, 3'b100, 32'h10, 32'h000000CC, 32'h0, 1, "store_1xx_fault");
        check("fault_no_wenable", 32'(wen_low[0] - wl), 32'd0);
        do_req(0, 0, 3'b010, 32'hFFC, 32'h0, 32'hBEEF5A5A, 0, "lw_ffc_untouched");

        // Response back-pressure with a second request already waiting.
        resp_ready = 1'b0;
        do_req(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, "stall_lw", 1'b0);
        n = 0;
        while (!resp_valid[0] && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_resp_seen", 32'(resp_valid[0]), 32'd1);
        push_exp(0, 32'h00000080, 0, "after_stall_lbu");
        req_we = 1'b0; req_funct3 = 3'b100; req_addr = 32'h21; req_wdata = 32'h0;
        req_valid[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(resp_valid[0]), 32'd1);
            check("stall_rdata", resp_rdata[0], 32'hDEADBEEF);
            check("stall_fault", 32'(resp_fault[0]), 32'd0);
            check("stall_req_ready", 32'(req_ready[0]), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("handshake_valid_low", 32'(resp_valid[0]), 32'd0);
        check("handshake_ready_high", 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;
        check("next_req_accepted", 32'(req_ready[0]), 32'd0);
        req_valid[0] = 1'b0;
        drain(0, "after_stall_lbu");

        // Reset during ISSUE of a store must leave memory untouched.
        do_req(0, 1, 3'b010, 32'h40, 32'hDDCCBBAA, 32'h0, 0, "sw_40_prior");
        @(posedge clk); #1;
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h11223344;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        check("issue_wenable_low", 32'(wen[0]), 32'h0);
        #1 rst = 1'b1;
        #1;
        check("rst_issue_wenableL", 32'(wen[0]), 32'hF);
        check("rst_issue_idle", 32'(req_ready[0]), 32'd1);
        check("rst_issue_no_resp", 32'(resp_valid[0]), 32'd0);
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        do_req(0, 0, 3'b010, 32'h40, 32'h0, 32'hDDCCBBAA, 0, "lw_40_after_abort");

        do_req(1, 1, 3'b010, 32'h00, 32'h34000000, 32'h0, 0, "mis_sw_00");
        do_req(1, 1, 3'b000, 32'h04, 32'h00000092, 32'h0, 0, "mis_sb_04");
        do_req(1, 0, 3'b001, 32'h03, 32'h0, 32'hFFFF9234, 0, "mis_lh_03");
        do_req(1, 0, 3'b010, 32'h01, 32'h0, 32'h92340000, 0, "mis_lw_01");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
